// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
//   lsu_state_e : FSM states (idle, busy waiting on memory, done/retire)
//   lsu_size_e  : access width decoded from funct3
//   Funct3*     : RISC-V load/store funct3 encodings
//   funct3_size : funct3 -> access width; undefined encodings decode as word
package lsu_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SizeByte = 2'd0,
    SizeHalf = 2'd1,
    SizeWord = 2'd2
  } lsu_size_e;

  localparam logic [2:0] Funct3B  = 3'b000;
  localparam logic [2:0] Funct3H  = 3'b001;
  localparam logic [2:0] Funct3W  = 3'b010;
  localparam logic [2:0] Funct3Bu = 3'b100;
  localparam logic [2:0] Funct3Hu = 3'b101;

  function automatic lsu_size_e funct3_size(logic [2:0] funct3);
    lsu_size_e size;
    case (funct3)
      Funct3B, Funct3Bu: size = SizeByte;
      Funct3H, Funct3Hu: size = SizeHalf;
      default:           size = SizeWord;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational extraction of the addressed byte/halfword from a
// 32-bit memory word, with sign or zero extension.
//   word_i   : raw word returned by memory
//   offset_i : low two bits of the byte address
//   funct3_i : load type (b/h/w/bu/hu; undefined encodings behave as word)
//   data_o   : extended load result
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        is_unsigned;

  always_comb begin
    case (offset_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    // Halfword uses addr[1] only; addr[0] is ignored when not trapped.
    half_sel    = offset_i[1] ? word_i[31:16] : word_i[15:0];
    is_unsigned = funct3_i[2];

    case (funct3_size(funct3_i))
      SizeByte: data_o = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      SizeHalf: data_o = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      default:  data_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store unit between the core and a
// word-wide memory with a req/ack handshake.
//   clk, reset (async, active-high)
//   Core side  : req_valid, req_we, req_funct3, req_addr, req_wdata in;
//                stall, rdata, rdata_valid, misalign out
//   Memory side: mem_req, mem_we, mem_addr (word aligned), mem_wdata, mem_be out;
//                mem_ack, mem_rdata in
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses (no memory request, misalign pulse). Without it misalign is 0 and the
// offending low address bits are ignored.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        misalign,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        we_q, we_d;
  logic        misalign_q, misalign_d;

  logic [3:0]  store_be;
  logic [31:0] store_wdata;
  logic        req_misaligned;
  logic [31:0] load_data;

  // Store lane steering: replicate data across lanes, select lanes with be.
  always_comb begin
    store_be    = 4'b1111;
    store_wdata = req_wdata;
    case (funct3_size(req_funct3))
      SizeByte: begin
        store_be    = 4'b0001 << req_addr[1:0];
        store_wdata = {4{req_wdata[7:0]}};
      end
      SizeHalf: begin
        store_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        store_wdata = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    req_misaligned = 1'b0;
    case (funct3_size(req_funct3))
      SizeHalf: req_misaligned = req_addr[0];
      SizeWord: req_misaligned = |req_addr[1:0];
      default:  req_misaligned = 1'b0;
    endcase
  end
`else
  assign req_misaligned = 1'b0;
`endif

  lsu_load_align u_load_align (
    .word_i   (mem_rdata),
    .offset_i (addr_q[1:0]),
    .funct3_i (funct3_q),
    .data_o   (load_data)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    be_d        = be_q;
    funct3_d    = funct3_q;
    we_d        = we_q;
    misalign_d  = misalign_q;
    stall       = 1'b0;
    mem_req     = 1'b0;
    rdata_valid = 1'b0;
    misalign    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          stall = 1'b1;
          if (req_misaligned) begin
            // Trapped: retire straight away without touching memory.
            misalign_d = 1'b1;
            state_d    = StDone;
          end else begin
            addr_d     = req_addr;
            we_d       = req_we;
            be_d       = req_we ? store_be : 4'b1111;
            wdata_d    = store_wdata;
            funct3_d   = req_funct3;
            misalign_d = 1'b0;
            state_d    = StBusy;
          end
        end
      end
      StBusy: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_ack) begin
          if (!we_q) begin
            rdata_d = load_data;
          end
          state_d = StDone;
        end
      end
      StDone: begin
        // Core is retiring this instruction; any req_valid here is ignored.
        rdata_valid = 1'b1;
        misalign    = misalign_q;
        misalign_d  = 1'b0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      be_q       <= '0;
      funct3_q   <= '0;
      we_q       <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      be_q       <= be_d;
      funct3_q   <= funct3_d;
      we_q       <= we_d;
      misalign_q <= misalign_d;
    end
  end

  assign rdata     = rdata_q;
  assign mem_we    = we_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;

endmodule
